// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-controller bundle: pipeline status into the controller, stage-register
// controls and event counters back out to the datapath.
interface pipeline_hazard_ctrl_if;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_use_rs;
  logic        id_use_rt;
  logic        ex_memtoreg;
  logic [4:0]  ex_wbregnum;
  logic        ex_redirect;
  logic        mem_access;
  logic        halt_req;
  logic        go;
  logic        clr_cnt;

  logic        pc_en;
  logic        ifid_en;
  logic        idex_en;
  logic        exmem_en;
  logic        memwb_en;
  logic        ifid_clr;
  logic        idex_bb;
  logic        exmem_bb;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [15:0] flush_cnt;

  // Datapath side.
  modport master (
    output id_rs, id_rt, id_use_rs, id_use_rt, ex_memtoreg, ex_wbregnum,
           ex_redirect, mem_access, halt_req, go, clr_cnt,
    input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_bb,
           exmem_bb, halted, stall_cnt, flush_cnt
  );

  // Controller side.
  modport slave (
    input  id_rs, id_rt, id_use_rs, id_use_rt, ex_memtoreg, ex_wbregnum,
           ex_redirect, mem_access, halt_req, go, clr_cnt,
    output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_clr, idex_bb,
           exmem_bb, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: multi-cycle MEM freeze, load-use stall,
// EX redirect flush, SYSCALL halt/resume, and saturating stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int MEM_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipeline_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    HALT  = 2'd2
  } state_e;

  localparam bit         MEM_MULTI = (MEM_LAT >= 2);
  localparam logic [3:0] WAIT_INIT = MEM_MULTI ? 4'(MEM_LAT - 2) : 4'd0;
  localparam logic [15:0] CNT_MAX  = 16'hFFFF;

  state_e      state_q, state_d;
  logic [3:0]  wait_q, wait_d;
  logic [15:0] stall_q, stall_d;
  logic [15:0] flush_q, flush_d;

  logic freeze;
  logic eval;
  logic halted;
  logic load_use;
  logic redirect_act;
  logic stall_act;

  assign load_use = hz.ex_memtoreg && (hz.ex_wbregnum != 5'd0) &&
                    ((hz.id_use_rs && (hz.id_rs == hz.ex_wbregnum)) ||
                     (hz.id_use_rt && (hz.id_rt == hz.ex_wbregnum)));

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    freeze  = 1'b0;
    eval    = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (hz.halt_req) begin
          state_d = HALT;
        end else if (hz.mem_access && MEM_MULTI) begin
          freeze  = 1'b1;
          wait_d  = WAIT_INIT;
          state_d = MWAIT;
        end else begin
          eval = 1'b1;
        end
      end
      MWAIT: begin
        // WB is frozen here, so a pending halt_req simply re-presents in RUN.
        if (wait_q != 4'd0) begin
          freeze = 1'b1;
          wait_d = wait_q - 4'd1;
        end else begin
          eval    = 1'b1;
          state_d = RUN;
        end
      end
      HALT: begin
        if (hz.go) begin
          state_d = RUN;
        end else begin
          freeze = 1'b1;
          halted = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Redirect outranks load-use; the flushed ID instruction cannot stall.
  assign redirect_act = eval && hz.ex_redirect;
  assign stall_act    = eval && load_use && !hz.ex_redirect;

  always_comb begin
    hz.pc_en    = !freeze && !stall_act;
    hz.ifid_en  = !freeze && !stall_act;
    hz.idex_en  = !freeze;
    hz.exmem_en = !freeze;
    hz.memwb_en = !freeze;
    hz.ifid_clr = redirect_act;
    hz.idex_bb  = redirect_act || stall_act;
    hz.exmem_bb = 1'b0;
    hz.halted   = halted;
    if (!rst_n) begin
      hz.pc_en    = 1'b0;
      hz.ifid_en  = 1'b0;
      hz.idex_en  = 1'b0;
      hz.exmem_en = 1'b0;
      hz.memwb_en = 1'b0;
      hz.ifid_clr = 1'b0;
      hz.idex_bb  = 1'b0;
      hz.halted   = 1'b0;
    end
  end

  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (hz.clr_cnt) begin
      stall_d = 16'd0;
      flush_d = 16'd0;
    end else begin
      if (stall_act && (stall_q != CNT_MAX)) stall_d = stall_q + 16'd1;
      if (redirect_act && (flush_q != CNT_MAX)) flush_d = flush_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      wait_q  <= 4'd0;
      stall_q <= 16'd0;
      flush_q <= 16'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      stall_q <= stall_d;
      flush_q <= flush_d;
    end
  end

  assign hz.stall_cnt = stall_q;
  assign hz.flush_cnt = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: MEM_LAT=4 main instance plus a
// MEM_LAT=1 instance sharing the same inputs.
module tb_pipeline_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipeline_hazard_ctrl_if bus4 ();
  pipeline_hazard_ctrl_if bus1 ();

  pipeline_hazard_ctrl #(.MEM_LAT(4)) dut4 (.clk(clk), .rst_n(rst_n), .hz(bus4.slave));
  pipeline_hazard_ctrl #(.MEM_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .hz(bus1.slave));

  assign bus1.id_rs       = bus4.id_rs;
  assign bus1.id_rt       = bus4.id_rt;
  assign bus1.id_use_rs   = bus4.id_use_rs;
  assign bus1.id_use_rt   = bus4.id_use_rt;
  assign bus1.ex_memtoreg = bus4.ex_memtoreg;
  assign bus1.ex_wbregnum = bus4.ex_wbregnum;
  assign bus1.ex_redirect = bus4.ex_redirect;
  assign bus1.mem_access  = bus4.mem_access;
  assign bus1.halt_req    = bus4.halt_req;
  assign bus1.go          = bus4.go;
  assign bus1.clr_cnt     = bus4.clr_cnt;

  // {pc, ifid, idex, exmem, memwb enables, ifid_clr, idex_bb, exmem_bb, halted}
  logic [8:0] o4, o1;
  assign o4 = {bus4.pc_en, bus4.ifid_en, bus4.idex_en, bus4.exmem_en, bus4.memwb_en,
               bus4.ifid_clr, bus4.idex_bb, bus4.exmem_bb, bus4.halted};
  assign o1 = {bus1.pc_en, bus1.ifid_en, bus1.idex_en, bus1.exmem_en, bus1.memwb_en,
               bus1.ifid_clr, bus1.idex_bb, bus1.exmem_bb, bus1.halted};

  localparam logic [8:0] O_RST    = 9'b00000_0000;
  localparam logic [8:0] O_NORM   = 9'b11111_0000;
  localparam logic [8:0] O_STALL  = 9'b00111_0100;
  localparam logic [8:0] O_FLUSH  = 9'b11111_1100;
  localparam logic [8:0] O_FREEZE = 9'b00000_0000;
  localparam logic [8:0] O_HALT   = 9'b00000_0001;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus4.id_rs       = 5'd0;
    bus4.id_rt       = 5'd0;
    bus4.id_use_rs   = 1'b0;
    bus4.id_use_rt   = 1'b0;
    bus4.ex_memtoreg = 1'b0;
    bus4.ex_wbregnum = 5'd0;
    bus4.ex_redirect = 1'b0;
    bus4.mem_access  = 1'b0;
    bus4.halt_req    = 1'b0;
    bus4.go          = 1'b0;
    bus4.clr_cnt     = 1'b0;
  endtask

  task automatic load_use_rs(input logic [4:0] r);
    bus4.ex_memtoreg = 1'b1;
    bus4.ex_wbregnum = r;
    bus4.id_rs       = r;
    bus4.id_use_rs   = 1'b1;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #1;
    check("reset_outs", 32'(o4), 32'(O_RST));
    check("reset_stall", 32'(bus4.stall_cnt), 32'd0);
    check("reset_flush", 32'(bus4.flush_cnt), 32'd0);
    #12 rst_n = 1'b1;
    #1;
    check("run_after_reset", 32'(o4), 32'(O_NORM));
    tick();

    // Load-use through rs, then the r0 exemption, then through rt.
    load_use_rs(5'd5);
    #1 check("lu_rs_outs", 32'(o4), 32'(O_STALL));
    tick();
    check("lu_rs_cnt", 32'(bus4.stall_cnt), 32'd1);
    load_use_rs(5'd0);
    #1 check("lu_r0_outs", 32'(o4), 32'(O_NORM));
    tick();
    check("lu_r0_cnt", 32'(bus4.stall_cnt), 32'd1);
    idle();
    bus4.ex_memtoreg = 1'b1;
    bus4.ex_wbregnum = 5'd7;
    bus4.id_rt       = 5'd7;
    bus4.id_rs       = 5'd5;
    #1 check("rt_unused_outs", 32'(o4), 32'(O_NORM));
    bus4.id_use_rt = 1'b1;
    #1 check("lu_rt_outs", 32'(o4), 32'(O_STALL));
    tick();
    check("lu_rt_cnt", 32'(bus4.stall_cnt), 32'd2);

    // Redirect alone, then redirect with a simultaneous load-use.
    idle();
    bus4.ex_redirect = 1'b1;
    #1 check("redir_outs", 32'(o4), 32'(O_FLUSH));
    tick();
    check("redir_cnt", 32'(bus4.flush_cnt), 32'd1);
    load_use_rs(5'd9);
    #1 check("redir_lu_outs", 32'(o4), 32'(O_FLUSH));
    tick();
    check("redir_lu_flush", 32'(bus4.flush_cnt), 32'd2);
    check("redir_lu_stall", 32'(bus4.stall_cnt), 32'd2);

    // MEM_LAT=4 freeze with redirect held: 3 frozen cycles, redirect on release.
    idle();
    bus4.mem_access  = 1'b1;
    bus4.ex_redirect = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check($sformatf("freeze_%0d", i), 32'(o4), 32'(O_FREEZE));
      check($sformatf("lat1_nofreeze_%0d", i), 32'(o1), 32'(O_FLUSH));
      tick();
    end
    check("freeze_no_count", 32'(bus4.flush_cnt), 32'd2);
    #1 check("release_outs", 32'(o4), 32'(O_FLUSH));
    tick();
    check("release_count", 32'(bus4.flush_cnt), 32'd3);
    idle();
    #1 check("back_to_run", 32'(o4), 32'(O_NORM));
    tick();

    // halt_req during MWAIT is ignored and takes effect once back in RUN.
    bus4.mem_access = 1'b1;
    #1 check("hw_freeze0", 32'(o4), 32'(O_FREEZE));
    tick();
    bus4.mem_access = 1'b0;
    bus4.halt_req   = 1'b1;
    tick();
    #1 check("hw_freeze2", 32'(o4), 32'(O_FREEZE));
    tick();
    #1 check("hw_release", 32'(o4), 32'(O_NORM));
    tick();
    #1 check("halt_req_run", 32'(o4), 32'(O_NORM));
    tick();
    bus4.halt_req    = 1'b0;
    bus4.ex_redirect = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check($sformatf("halted_%0d", i), 32'(o4), 32'(O_HALT));
      tick();
    end
    check("halt_no_flush", 32'(bus4.flush_cnt), 32'd3);
    bus4.ex_redirect = 1'b0;
    bus4.go          = 1'b1;
    #1 check("go_outs", 32'(o4[8:4]), 32'(5'b11111));
    tick();
    bus4.go = 1'b0;
    #1 check("after_go", 32'(o4), 32'(O_NORM));

    // Counter clear, saturation, and clear beating an increment.
    bus4.clr_cnt = 1'b1;
    tick();
    check("clr_stall", 32'(bus4.stall_cnt), 32'd0);
    check("clr_flush", 32'(bus4.flush_cnt), 32'd0);
    bus4.clr_cnt = 1'b0;
    load_use_rs(5'd3);
    repeat (65535) @(posedge clk);
    #1 check("stall_at_max", 32'(bus4.stall_cnt), 32'hFFFF);
    tick();
    check("stall_saturated", 32'(bus4.stall_cnt), 32'hFFFF);
    bus4.clr_cnt = 1'b1;
    #1 check("clr_lu_outs", 32'(o4), 32'(O_STALL));
    tick();
    check("clr_over_inc", 32'(bus4.stall_cnt), 32'd0);

    // Reset asserted mid-MWAIT abandons the wait and clears the counters.
    idle();
    bus4.ex_redirect = 1'b1;
    tick();
    check("pre_rst_flush", 32'(bus4.flush_cnt), 32'd1);
    idle();
    bus4.mem_access = 1'b1;
    tick();
    bus4.mem_access = 1'b0;
    #1 check("mwait_frozen", 32'(o4), 32'(O_FREEZE));
    #1 rst_n = 1'b0;
    #1 check("rst_mwait_outs", 32'(o4), 32'(O_RST));
    check("rst_mwait_flush", 32'(bus4.flush_cnt), 32'd0);
    #1 rst_n = 1'b1;
    #1 check("rst_release_run", 32'(o4), 32'(O_NORM));
    tick();
    check("run_after_rel", 32'(o4), 32'(O_NORM));
    check("cnt_after_rel", 32'({bus4.stall_cnt, bus4.flush_cnt}), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have parameter MEM_LAT, default 2, cycles an instruction occupies the MEM stage when it accesses memory; legal range 1..16.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- id_rs, id_rt  in  5 each  source register numbers in ID.
- id_use_rs, id_use_rt  in  1 each  ID instruction reads rs / rt.
- ex_memtoreg  in  1  EX instruction is a load.
- ex_wbregnum  in  5  EX destination register.
- ex_redirect  in  1  taken branch or jump resolved in EX.
- mem_access  in  1  MEM instruction reads or writes data memory.
- halt_req  in  1  WB holds a terminating SYSCALL.
- go  in  1  resume pulse while halted.
- clr_cnt  in  1  synchronous clear of both counters.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage-register enables.
- ifid_clr  out  1  IF/ID synchronous clear.
- idex_bb, exmem_bb  out  1 each  bubble inject, effective only with the matching en=1.
- halted  out  1  block is in HALT.
- stall_cnt, flush_cnt  out  16 each  event counters.

Function
REQ-003 SHALL implement states RUN, MWAIT and HALT, plus a 4-bit wait_cnt.
REQ-004 In RUN, with no event active, SHALL drive all en=1 and all clr/bb=0.
REQ-005 Load-use SHALL be ex_memtoreg=1 and ex_wbregnum!=0 and ((id_use_rs and id_rs==ex_wbregnum) or (id_use_rt and id_rt==ex_wbregnum)).
REQ-006 Per-cycle priority in RUN: halt_req (outputs normal this cycle), then mem_access, then ex_redirect, then load-use.
REQ-007 On halt_req=1 in RUN: SHALL drive normal outputs this cycle, then go to HALT on the next edge.
REQ-008 HALT: SHALL drive all en=0, all clr/bb=0 and halted=1. On go=1: SHALL drive outputs as RUN with no events this cycle and move to RUN on the next edge.
REQ-009 mem_access=1 in RUN with MEM_LAT>=2:
- freeze this cycle: all en=0, clr/bb=0;
- wait_cnt <= MEM_LAT-2;
- state <= MWAIT.
REQ-010 MEM_LAT=1: SHALL ignore mem_access; no freeze.
REQ-011 MWAIT with wait_cnt!=0: SHALL freeze and decrement wait_cnt. MWAIT with wait_cnt==0: release cycle, outputs per REQ-012..014 rules, next state RUN. Total freeze is exactly MEM_LAT-1 cycles per access.
REQ-012 ex_redirect (not frozen) SHALL drive pc_en=1, ifid_en=1, ifid_clr=1, idex_en=1, idex_bb=1, other stages normal, and increment flush_cnt.
REQ-013 Load-use (not frozen, no redirect) SHALL drive pc_en=0, ifid_en=0, idex_en=1, idex_bb=1, exmem_en=1, memwb_en=1, and increment stall_cnt.
REQ-014 Load-use coinciding with ex_redirect SHALL act as redirect only, with stall_cnt unchanged.
REQ-015 Redirect or load-use during a freeze cycle SHALL be ignored, with no count. The held EX/ID contents are re-evaluated on the release cycle.
REQ-016 halt_req in MWAIT SHALL be ignored. WB is frozen, so the request persists into RUN.
REQ-017 exmem_bb SHALL always be 0; it is reserved for exception flush.
REQ-018 Counters SHALL saturate at 16'hFFFF. clr_cnt=1 SHALL zero both counters and take priority over an increment in the same cycle.
REQ-019 Outputs SHALL be combinational from state, wait_cnt and the current inputs. Only state, wait_cnt and the counters are registered.

Reset
REQ-020 While rst_n=0, regardless of clk: state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0.
REQ-021 While rst_n=0: all en=0, ifid_clr=0, idex_bb=0, exmem_bb=0, halted=0.
REQ-022 After rst_n rises: outputs per RUN from the first edge. Reset asserted in MWAIT or HALT SHALL abandon that state immediately.

Verification
REQ-023 Load-use: ex_memtoreg=1, ex_wbregnum=5, id_rs=5, id_use_rs=1, one cycle -> pc_en=0, ifid_en=0, idex_bb=1, idex_en=1; stall_cnt=1. Repeat with ex_wbregnum=0 -> no stall.
REQ-024 MEM_LAT=4, mem_access held high -> exactly 3 freeze cycles (all en=0), then one cycle all en=1, then RUN. With MEM_LAT=1 -> no freeze.
REQ-025 ex_redirect and load-use in the same cycle -> ifid_clr=1, idex_bb=1, pc_en=1; flush_cnt +1, stall_cnt unchanged.
REQ-026 halt_req one cycle -> from next cycle halted=1, all en=0 for 10 cycles. go pulse -> RUN outputs, halted=0 the following cycle.
REQ-027 Preset stall_cnt to 16'hFFFF via 65535 load-use cycles, then one more -> stays 16'hFFFF. clr_cnt with a simultaneous load-use -> 0. rst_n=0 mid-MWAIT -> immediate all en=0; after release, RUN with counters 0.
